matmul_apb_regfile: RTL and testbench

MATMUL_APB_REGFILE -- requirements
Module: matmul_apb_regfile

---
 rtl/matmul_apb_regfile_if.sv | 37 +++
 rtl/matmul_apb_regfile.sv | 229 ++++++++++++++++++++++
 tb/tb_matmul_apb_regfile.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_apb_regfile_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : matmul_apb_regfile_if                                        |
// | Description : APB bus bundle between a master and the matmul register     |
// |               file. Signal names are seen from the slave side (_i inputs, |
// |               _o outputs).                                                 |
// |   psel_i/penable_i/pwrite_i : transfer control                             |
// |   paddr_i/pwdata_i/pstrb_i  : byte address, write data, byte strobes       |
// |   pready_o/pslverr_o        : completion and error                         |
// |   prdata_o                  : read data                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface matmul_apb_regfile_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
);
   logic                    psel_i;
   logic                    penable_i;
   logic                    pwrite_i;
   logic [DATA_WIDTH/8-1:0] pstrb_i;
   logic [DATA_WIDTH-1:0]   pwdata_i;
   logic [ADDR_WIDTH-1:0]   paddr_i;
   logic                    pready_o;
   logic                    pslverr_o;
   logic [DATA_WIDTH-1:0]   prdata_o;

   modport master (
      output psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i, paddr_i,
      input  pready_o, pslverr_o, prdata_o
   );

   modport slave (
      input  psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i, paddr_i,
      output pready_o, pslverr_o, prdata_o
   );
endinterface
`default_nettype wire

// File: rtl/matmul_apb_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : matmul_apb_regfile                                           |
// | Description : APB register file for a matrix-multiply engine: CTRL,        |
// |               STATUS and an operand bank read by the engine.               |
// | Ports       : clk_i, rst_i (async, active high)                            |
// |               apb         : APB slave (matmul_apb_regfile_if.slave)        |
// |               start_o     : one-cycle engine start pulse                   |
// |               mode_o      : operation mode (CTRL[2:1])                     |
// |               done_i      : engine done pulse                              |
// |               eng_raddr_i : engine operand index                           |
// |               eng_rdata_o : operand word (combinational)                   |
// |               busy_o      : engine running                                 |
// |               irq_o       : only with MATMUL_APB_IRQ_EN defined            |
// | Options     : `define MATMUL_APB_IRQ_EN adds irq_o and CTRL bit3           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module matmul_apb_regfile #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 12,
   parameter int OPERAND_DEPTH = 16,
   parameter int WAIT_STATES   = 1
) (
   input  wire logic                             clk_i,
   input  wire logic                             rst_i,
   matmul_apb_regfile_if.slave                   apb,
   output logic                                  start_o,
   output logic [1:0]                            mode_o,
   input  wire logic                             done_i,
   input  wire logic [$clog2(OPERAND_DEPTH)-1:0] eng_raddr_i,
   output logic [DATA_WIDTH-1:0]                 eng_rdata_o,
   output logic                                  busy_o
`ifdef MATMUL_APB_IRQ_EN
   ,
   output logic                                  irq_o
`endif
);

   localparam int C_BYTES = DATA_WIDTH / 8;
   localparam int C_BSH   = $clog2(C_BYTES);
   localparam int C_IDX_W = $clog2(OPERAND_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] C_ADDR_CTRL   = ADDR_WIDTH'('h000);
   localparam logic [ADDR_WIDTH-1:0] C_ADDR_STATUS = ADDR_WIDTH'('h004);
   localparam logic [ADDR_WIDTH-1:0] C_BANK_BASE   = ADDR_WIDTH'('h100);
   // The IDLE cycle that sees the access phase already counts as the first
   // wait cycle, so WAIT itself only covers the remaining WAIT_STATES-1.
   localparam logic [1:0] C_WAIT_LOAD = (WAIT_STATES > 1) ? 2'(WAIT_STATES - 2) : 2'd0;
`ifdef MATMUL_APB_IRQ_EN
   localparam logic C_IRQ_EN = 1'b1;
`else
   localparam logic C_IRQ_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            wcnt_q, wcnt_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
   logic                  slverr_q, slverr_d;
   logic [3:1]            ctrl_q, ctrl_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic                  start_q, start_d;
   logic [DATA_WIDTH-1:0] bank_q [OPERAND_DEPTH];
   logic [DATA_WIDTH-1:0] bank_d [OPERAND_DEPTH];

   logic [ADDR_WIDTH-1:0] bank_off;
   logic [C_IDX_W-1:0]    bank_idx;
   logic                  hit_ctrl, hit_status, hit_bank;
   logic                  wr_any, acc_err, go_resp, commit;
   logic [DATA_WIDTH-1:0] rd_val;

   // Address decode, error classification and read mux for the current bus.
   always_comb begin
      bank_off   = apb.paddr_i - C_BANK_BASE;
      hit_ctrl   = (apb.paddr_i == C_ADDR_CTRL);
      hit_status = (apb.paddr_i == C_ADDR_STATUS);
      hit_bank   = (apb.paddr_i >= C_BANK_BASE) && (bank_off[C_BSH-1:0] == '0) &&
                   ((bank_off >> C_BSH) < ADDR_WIDTH'(OPERAND_DEPTH));
      bank_idx   = bank_off[C_BSH +: C_IDX_W];
      // A write with no strobes touches nothing, so it cannot collide with busy.
      wr_any     = apb.pwrite_i & (|apb.pstrb_i);
      rd_val     = '0;
      acc_err    = 1'b0;
      if (hit_ctrl) begin
         rd_val[3:1] = ctrl_q;
         acc_err     = wr_any & busy_q;
      end else if (hit_status) begin
         rd_val[1:0] = {done_q, busy_q};
      end else if (hit_bank) begin
         rd_val  = bank_q[bank_idx];
         acc_err = wr_any & busy_q;
      end else begin
         acc_err = 1'b1;
      end
   end

   // Slave FSM; the response is loaded on the edge into RESP so that it is
   // presented together with pready_o.
   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      prdata_d = prdata_q;
      slverr_d = slverr_q;
      go_resp  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (apb.psel_i && apb.penable_i) begin
               if (WAIT_STATES <= 1) begin
                  go_resp = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  wcnt_d  = C_WAIT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (!apb.psel_i) begin
               state_d = ST_IDLE;
            end else if (wcnt_q == 2'd0) begin
               go_resp = 1'b1;
            end else begin
               wcnt_d = wcnt_q - 2'd1;
            end
         end
         ST_RESP: begin
            state_d  = ST_IDLE;
            prdata_d = '0;
            slverr_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
      if (go_resp) begin
         state_d  = ST_RESP;
         slverr_d = acc_err;
         prdata_d = acc_err ? '0 : rd_val;
      end
   end

   // Register updates; bus writes land on the edge that ends RESP.
   always_comb begin
      ctrl_d  = ctrl_q;
      done_d  = done_q;
      busy_d  = busy_q;
      start_d = 1'b0;
      bank_d  = bank_q;
      commit  = (state_q == ST_RESP) && apb.pwrite_i && !slverr_q;
      if (commit && hit_ctrl && apb.pstrb_i[0]) begin
         ctrl_d[2:1] = apb.pwdata_i[2:1];
         ctrl_d[3]   = apb.pwdata_i[3] & C_IRQ_EN;
         start_d     = apb.pwdata_i[0];
      end
      if (commit && hit_status && apb.pstrb_i[0] && apb.pwdata_i[1]) begin
         done_d = 1'b0;
      end
      if (commit && hit_bank) begin
         for (int b = 0; b < C_BYTES; b++) begin
            if (apb.pstrb_i[b]) begin
               bank_d[bank_idx][8*b +: 8] = apb.pwdata_i[8*b +: 8];
            end
         end
      end
      if (start_d) begin
         busy_d = 1'b1;
      end else if (done_i && busy_q) begin
         busy_d = 1'b0;
      end
      // Engine completion wins over a simultaneous write-1-clear.
      if (done_i && busy_q) begin
         done_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         wcnt_q   <= 2'd0;
         prdata_q <= '0;
         slverr_q <= 1'b0;
         ctrl_q   <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         start_q  <= 1'b0;
         for (int i = 0; i < OPERAND_DEPTH; i++) begin
            bank_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         prdata_q <= prdata_d;
         slverr_q <= slverr_d;
         ctrl_q   <= ctrl_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         start_q  <= start_d;
         bank_q   <= bank_d;
      end
   end

   assign apb.pready_o  = (state_q == ST_RESP);
   assign apb.pslverr_o = slverr_q;
   assign apb.prdata_o  = prdata_q;
   assign start_o       = start_q;
   assign busy_o        = busy_q;
   assign mode_o        = ctrl_q[2:1];
   assign eng_rdata_o   = ({1'b0, eng_raddr_i} < (C_IDX_W + 1)'(OPERAND_DEPTH)) ?
                          bank_q[eng_raddr_i] : '0;

`ifdef MATMUL_APB_IRQ_EN
   logic irq_q, irq_d;
   always_comb begin
      irq_d = done_q & ctrl_q[3];
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end
   assign irq_o = irq_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matmul_apb_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_matmul_apb_regfile                                        |
// | Description : Directed, table-driven bench for matmul_apb_regfile          |
// |               (DATA_WIDTH=32, ADDR_WIDTH=12, OPERAND_DEPTH=16,             |
// |               WAIT_STATES=1).                                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_matmul_apb_regfile;
   logic       clk = 1'b0;
   logic       rst_i;
   logic       start_o;
   logic [1:0] mode_o;
   logic       done_i;
   logic [3:0] eng_raddr_i;
   logic [31:0] eng_rdata_o;
   logic       busy_o;
`ifdef MATMUL_APB_IRQ_EN
   logic       irq_o;
`endif

   matmul_apb_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) apb ();

   matmul_apb_regfile #(
      .DATA_WIDTH(32), .ADDR_WIDTH(12), .OPERAND_DEPTH(16), .WAIT_STATES(1)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .apb         (apb),
      .start_o     (start_o),
      .mode_o      (mode_o),
      .done_i      (done_i),
      .eng_raddr_i (eng_raddr_i),
      .eng_rdata_o (eng_rdata_o),
      .busy_o      (busy_o)
`ifdef MATMUL_APB_IRQ_EN
      ,
      .irq_o       (irq_o)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        wr;
      logic [11:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [19];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input logic wr, input logic [11:0] addr,
                          input logic [3:0] strb, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
      vecs[i].wr        = wr;
      vecs[i].addr      = addr;
      vecs[i].strb      = strb;
      vecs[i].wdata     = wdata;
      vecs[i].exp_rdata = exp_rdata;
      vecs[i].exp_err   = exp_err;
   endtask

   // One APB transfer; returns sampled response and the access cycle on
   // which pready_o was seen (0 on timeout). Optionally pulses done_i in the
   // response cycle.
   task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [3:0] strb,
                           input logic [31:0] wdata, input bit done_in_resp,
                           output logic [31:0] rdata, output logic err, output int ncyc);
      bit got;
      got   = 1'b0;
      ncyc  = 0;
      rdata = '0;
      err   = 1'b0;
      @(posedge clk); #1;
      apb.psel_i    = 1'b1;
      apb.penable_i = 1'b0;
      apb.pwrite_i  = wr;
      apb.paddr_i   = addr;
      apb.pstrb_i   = strb;
      apb.pwdata_i  = wdata;
      @(posedge clk); #1;
      apb.penable_i = 1'b1;
      for (int i = 1; i <= 10 && !got; i++) begin
         @(negedge clk);
         if (apb.pready_o) begin
            got   = 1'b1;
            ncyc  = i;
            rdata = apb.prdata_o;
            err   = apb.pslverr_o;
            if (done_in_resp) done_i = 1'b1;
         end
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout addr 0x%0h: no pready_o within 10 cycles", addr);
      end
      @(posedge clk); #1;
      apb.psel_i    = 1'b0;
      apb.penable_i = 1'b0;
      done_i        = 1'b0;
   endtask

   task automatic do_write(input string name, input logic [11:0] addr, input logic [3:0] strb,
                           input logic [31:0] wdata, input logic exp_err);
      logic [31:0] rd;
      logic        er;
      int          nc;
      apb_xfer(1'b1, addr, strb, wdata, 1'b0, rd, er, nc);
      check({name, " err"}, er, exp_err);
   endtask

   task automatic do_read(input string name, input logic [11:0] addr,
                          input logic [31:0] exp_rdata, input logic exp_err);
      logic [31:0] rd;
      logic        er;
      int          nc;
      apb_xfer(1'b0, addr, 4'h0, 32'h0, 1'b0, rd, er, nc);
      check({name, " rdata"}, rd, exp_rdata);
      check({name, " err"}, er, exp_err);
   endtask

   task automatic pulse_done();
      @(posedge clk); #1;
      done_i = 1'b1;
      @(posedge clk); #1;
      done_i = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          nc;

      rst_i         = 1'b1;
      done_i        = 1'b0;
      eng_raddr_i   = 4'd0;
      apb.psel_i    = 1'b0;
      apb.penable_i = 1'b0;
      apb.pwrite_i  = 1'b0;
      apb.paddr_i   = '0;
      apb.pstrb_i   = '0;
      apb.pwdata_i  = '0;

      set_vec( 0, 1'b0, 12'h000, 4'h0, 32'h0,        32'h0,        1'b0);
      set_vec( 1, 1'b0, 12'h004, 4'h0, 32'h0,        32'h0,        1'b0);
      set_vec( 2, 1'b1, 12'h104, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0);
      set_vec( 3, 1'b0, 12'h104, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0);
      set_vec( 4, 1'b1, 12'h108, 4'h3, 32'h11223344, 32'h0,        1'b0);
      set_vec( 5, 1'b0, 12'h108, 4'h0, 32'h0,        32'h00003344, 1'b0);
      set_vec( 6, 1'b1, 12'h10C, 4'h0, 32'hAABBCCDD, 32'h0,        1'b0);
      set_vec( 7, 1'b0, 12'h10C, 4'h0, 32'h0,        32'h0,        1'b0);
      set_vec( 8, 1'b0, 12'h0F0, 4'h0, 32'h0,        32'h0,        1'b1);
      set_vec( 9, 1'b0, 12'h102, 4'h0, 32'h0,        32'h0,        1'b1);
      set_vec(10, 1'b1, 12'h140, 4'hF, 32'h1,        32'h0,        1'b1);
      set_vec(11, 1'b1, 12'h13C, 4'hC, 32'h12345678, 32'h0,        1'b0);
      set_vec(12, 1'b0, 12'h13C, 4'h0, 32'h0,        32'h12340000, 1'b0);
      set_vec(13, 1'b1, 12'h000, 4'h1, 32'h4,        32'h0,        1'b0);
      set_vec(14, 1'b0, 12'h000, 4'h0, 32'h0,        32'h4,        1'b0);
      set_vec(15, 1'b1, 12'h000, 4'h1, 32'h8,        32'h0,        1'b0);
`ifdef MATMUL_APB_IRQ_EN
      set_vec(16, 1'b0, 12'h000, 4'h0, 32'h0,        32'h8,        1'b0);
`else
      set_vec(16, 1'b0, 12'h000, 4'h0, 32'h0,        32'h0,        1'b0);
`endif
      set_vec(17, 1'b1, 12'h004, 4'hF, 32'h0,        32'h0,        1'b0);
      set_vec(18, 1'b0, 12'h008, 4'h0, 32'h0,        32'h0,        1'b1);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset pready",  apb.pready_o,  1'b0);
      check("reset pslverr", apb.pslverr_o, 1'b0);
      check("reset prdata",  apb.prdata_o,  32'h0);
      check("reset start",   start_o,       1'b0);
      check("reset busy",    busy_o,        1'b0);
      check("reset mode",    mode_o,        2'd0);
      @(posedge clk); #1;
      rst_i = 1'b0;

      // Table-driven accesses
      for (int i = 0; i < 19; i++) begin
         apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].strb, vecs[i].wdata, 1'b0, rd, er, nc);
         check($sformatf("vec%0d pready cycle", i), nc, 2);
         check($sformatf("vec%0d err", i), er, vecs[i].exp_err);
         if (!vecs[i].wr) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      end
      check("mode after ctrl writes", mode_o, 2'd0);
      eng_raddr_i = 4'd1; #1;
      check("eng rdata idx1", eng_rdata_o, 32'hDEADBEEF);
      eng_raddr_i = 4'd15; #1;
      check("eng rdata idx15", eng_rdata_o, 32'h12340000);
      eng_raddr_i = 4'd1;

      // Start / busy / done
      apb_xfer(1'b1, 12'h000, 4'h1, 32'h5, 1'b0, rd, er, nc);
      check("start err",    er,      1'b0);
      check("start pulse",  start_o, 1'b1);
      check("start busy",   busy_o,  1'b1);
      check("start mode",   mode_o,  2'd2);
      @(posedge clk); #1;
      check("start pulse end", start_o, 1'b0);
      check("busy held",       busy_o,  1'b1);
      do_write("bank write busy", 12'h104, 4'hF, 32'h0, 1'b1);
      do_read("bank unchanged", 12'h104, 32'hDEADBEEF, 1'b0);
      do_read("status busy", 12'h004, 32'h1, 1'b0);
      do_write("ctrl write busy", 12'h000, 4'h1, 32'h2, 1'b1);
      check("mode kept while busy", mode_o, 2'd2);
      check("no restart pulse", start_o, 1'b0);
      pulse_done();
      check("busy cleared", busy_o, 1'b0);
      do_read("status done", 12'h004, 32'h2, 1'b0);
      do_write("status w1c", 12'h004, 4'h1, 32'h2, 1'b0);
      do_read("status cleared", 12'h004, 32'h0, 1'b0);
      pulse_done();
      do_read("done ignored idle", 12'h004, 32'h0, 1'b0);

      // done_i coinciding with a write-1-clear of done
      do_write("prio start1", 12'h000, 4'h1, 32'h1, 1'b0);
      pulse_done();
      do_write("prio start2", 12'h000, 4'h1, 32'h1, 1'b0);
      check("prio busy", busy_o, 1'b1);
      apb_xfer(1'b1, 12'h004, 4'h1, 32'h2, 1'b1, rd, er, nc);
      check("prio w1c err", er, 1'b0);
      do_read("prio done kept", 12'h004, 32'h2, 1'b0);
      do_write("prio w1c later", 12'h004, 4'h1, 32'h2, 1'b0);
      do_read("prio done cleared", 12'h004, 32'h0, 1'b0);

      // Reset in the middle of a transfer
      do_write("mrst start", 12'h000, 4'h1, 32'h5, 1'b0);
      check("mrst busy before", busy_o, 1'b1);
      @(posedge clk); #1;
      apb.psel_i    = 1'b1;
      apb.penable_i = 1'b0;
      apb.pwrite_i  = 1'b1;
      apb.paddr_i   = 12'h104;
      apb.pstrb_i   = 4'hF;
      apb.pwdata_i  = 32'h00000077;
      @(posedge clk); #1;
      apb.penable_i = 1'b1;
      @(negedge clk);
      check("mrst pready waiting", apb.pready_o, 1'b0);
      rst_i = 1'b1;
      #1;
      apb.psel_i    = 1'b0;
      apb.penable_i = 1'b0;
      check("mrst pready",  apb.pready_o,  1'b0);
      check("mrst pslverr", apb.pslverr_o, 1'b0);
      check("mrst prdata",  apb.prdata_o,  32'h0);
      check("mrst start",   start_o,       1'b0);
      check("mrst busy",    busy_o,        1'b0);
      check("mrst mode",    mode_o,        2'd0);
      check("mrst bank",    eng_rdata_o,   32'h0);
      @(posedge clk);
      @(negedge clk);
      check("mrst pready held", apb.pready_o, 1'b0);
      rst_i = 1'b0;
      apb_xfer(1'b1, 12'h104, 4'hF, 32'h00000077, 1'b0, rd, er, nc);
      check("post rst write cycle", nc, 2);
      check("post rst write err", er, 1'b0);
      do_read("post rst readback", 12'h104, 32'h00000077, 1'b0);
      do_read("post rst status", 12'h004, 32'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
